fwrisc_regfile_mp: RTL and testbench
====================================

# fwrisc_regfile_mp

Parametrised multi-read-port register file for the fwrisc core, replacing the fixed two-port, 64-entry, 32-bit file. It is fully synchronous (registered read data), so it maps onto block RAM without vendor IP. After reset it clears every entry with an internal sweep and signals `ready` when done. Writes-to-read forwarding is optional. It sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_WIDTH`, default 32: register width in bits.
- `ADDR_WIDTH`, default 6: address width; depth is `DEPTH = 2**ADDR_WIDTH`.
- `NUM_RD_PORTS`, default 2: number of independent read ports, minimum 1.
- `clock`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `ready`, output, 1: high once the clear sweep is complete.
- `raddr`, input, `NUM_RD_PORTS*ADDR_WIDTH`: packed read addresses; port p uses bits `[p*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rdata`, output, `NUM_RD_PORTS*DATA_WIDTH`: packed registered read data, packed the same way.
- `rd_waddr`, input, `ADDR_WIDTH`: write address.
- `rd_wdata`, input, `DATA_WIDTH`: write data.
- `rd_wen`, input, 1: write enable.

## Operation
- The state machine has two states, `CLEAR` and `RUN`. A clear counter `clr_cnt` of `ADDR_WIDTH` bits sweeps the array.
- **Reset.** While `reset`=1 the state is forced to `CLEAR`, `clr_cnt` to 0, `ready` to 0 and all `rdata` to 0.
  - No array write happens in a reset cycle.
  - Reset asserted mid-sweep or mid-run restarts the sweep from 0.
- **CLEAR state.** Each cycle writes 0 to `regs[clr_cnt]` and increments `clr_cnt`.
  - When `clr_cnt == DEPTH-1` is written, the state moves to `RUN` and `ready` becomes 1 at that same edge.
  - `rd_wen` is ignored; external writes are dropped and not queued.
  - Reads are not performed; `rdata` is forced to 0.
- **RUN state.**
  - Write: when `rd_wen`=1 and `rd_waddr`≠0, `regs[rd_waddr]` ← `rd_wdata`.
  - Writes to address 0 are discarded. Entry 0 is always 0.
  - Read: on every edge, each port p captures `rdata[p]` ← 0 if `raddr[p]`==0, else `regs[raddr[p]]`.
  - Ports are independent. Any number of ports may read the same address.
- **Same-cycle write/read to one nonzero address:** see Configuration.
- **Arithmetic.** The counter does not wrap while in `RUN`; it holds at `DEPTH-1`. No other arithmetic.

## Timing
- **Read latency:** 1 cycle. An address presented before edge N gives its data on `rdata` after edge N, held until the next edge.
- **Write:** takes effect at the edge where `rd_wen` is sampled. A read issued in the next cycle returns the new value.
- **Clear duration:**
  - The first clear write is at the first edge with `reset`=0.
  - `ready` rises after edge number `DEPTH` counted from reset deassertion: 64 cycles at the default.
- **Reset values:** `ready`=0, every `rdata` lane=0.
- **Handshake:** none beyond `ready`. The consumer must not issue meaningful reads or writes while `ready`=0.

## Configuration
- Macro: `FWRISC_REGFILE_BYPASS_EN`.
- **Defined:** write-first behaviour.
  - In `RUN`, if `rd_wen`=1, `rd_waddr`≠0 and `rd_waddr`==`raddr[p]` in the same cycle, `rdata[p]` captures `rd_wdata`.
  - There is one comparator per port.
- **Undefined:** read-first behaviour.
  - `rdata[p]` captures the pre-write contents of the entry.
  - No comparators are built. This matches pure block-RAM read-first mode.
- Address-0 behaviour is identical in both modes: it always reads 0.

## Structure
- **Package `fwrisc_regfile_pkg`:**
  - `typedef enum logic {CLEAR, RUN} regfile_state_e`.
  - Default localparams for the width and depth.
- **Top module** owns the state machine, the clear counter, the write mux (clear write vs external write) and the storage array.
- **Sub-module `fwrisc_regfile_rdport`:** one instance per read port, via generate.
  - Holds the registered read, the zero-address force and the optional bypass comparator.
  - Parameterised by `DATA_WIDTH` and `ADDR_WIDTH`.

## Test plan
- **Reset and clear.** Write a nonzero value, then assert reset 3 cycles and release.
  - `ready`=0 for exactly 64 cycles, then 1.
  - Reading any address afterwards returns 0x00000000.
- **Basic write/read.** Write 0xDEADBEEF to addr 5, then read addr 5 on both ports in the next cycle.
  - Both `rdata` lanes show 0xDEADBEEF one cycle after the read.
- **Address 0.** Write 0xFFFFFFFF to addr 0, then read addr 0.
  - `rdata`=0.
- **Same-cycle collision.** Addr 7 holds 0x11111111. Write 0x22222222 to addr 7 while reading addr 7 on port 0.
  - With the macro defined, `rdata[0]`=0x22222222.
  - Without it, `rdata[0]`=0x11111111. The next read gives 0x22222222 in both modes.
- **Reset mid-clear.** Assert reset at cycle 30 of the sweep.
  - `ready` stays 0 and the sweep restarts. `ready` rises 64 cycles after the second release.
  - A write issued during the sweep is dropped, so that address reads 0.
- **Parameter variant.** Use `NUM_RD_PORTS`=3, `ADDR_WIDTH`=4, `DATA_WIDTH`=16.
  - Clear takes 16 cycles.
  - Three ports read three different addresses concurrently and each returns its own value.

Source files
------------

// File: rtl/fwrisc_regfile_pkg.sv
// Shared types and default sizes for the fwrisc multi-read-port register file.
package fwrisc_regfile_pkg;

  localparam int unsigned REGFILE_DATA_WIDTH_DEF = 32;
  localparam int unsigned REGFILE_ADDR_WIDTH_DEF = 6;
  localparam int unsigned REGFILE_NUM_RD_DEF     = 2;
  localparam int unsigned REGFILE_DEPTH_DEF      = 1 << REGFILE_ADDR_WIDTH_DEF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/fwrisc_regfile_rdport.sv
// One registered read port: zero-address force, optional write-first bypass.
// Optional feature macro: FWRISC_REGFILE_BYPASS_EN (write-first when defined,
// read-first otherwise).
module fwrisc_regfile_rdport
  import fwrisc_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = REGFILE_ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] arr_data_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Select the value captured at the next edge
  always_comb begin
    rdata_d = '0;
    if (run_i && (raddr_i != '0)) begin
`ifdef FWRISC_REGFILE_BYPASS_EN
      // wr_en_i is already qualified with a nonzero write address
      if (wr_en_i && (wr_addr_i == raddr_i)) begin
        rdata_d = wr_data_i;
      end else begin
        rdata_d = arr_data_i;
      end
`else
      rdata_d = arr_data_i;
`endif
    end
  end

`ifndef FWRISC_REGFILE_BYPASS_EN
  // Write-side inputs only feed the bypass comparator
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  // Registered read data, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fwrisc_regfile_mp.sv
// fwrisc register file: parameterised read ports, synchronous reads,
// post-reset clear sweep with ready flag.
// Optional feature macro: FWRISC_REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding on each port).
module fwrisc_regfile_mp
  import fwrisc_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = REGFILE_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = REGFILE_ADDR_WIDTH_DEF,
  parameter int unsigned NUM_RD_PORTS = REGFILE_NUM_RD_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               ready,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0]              rd_waddr,
  input  logic [DATA_WIDTH-1:0]              rd_wdata,
  input  logic                               rd_wen
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  regfile_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  clr_we_c;
  logic                  ext_we_c;
  logic                  run_c;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] arr_rd [NUM_RD_PORTS];

  // State, clear counter and ready registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic and write-source selection
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    clr_we_c  = 1'b0;
    ext_we_c  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we_c = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        ext_we_c = rd_wen && (rd_waddr != '0);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign run_c = (state_q == RUN);

  // Storage array: clear sweep writes zero, otherwise external write port
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we_c) begin
        regs[clr_cnt_q] <= '0;
      end else if (ext_we_c) begin
        regs[rd_waddr] <= rd_wdata;
      end
    end
  end

  // One registered read port per lane
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rdport
    assign arr_rd[p] = regs[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];

    fwrisc_regfile_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rdport (
      .clock      (clock),
      .reset      (reset),
      .run_i      (run_c),
      .raddr_i    (raddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .arr_data_i (arr_rd[p]),
      .wr_en_i    (ext_we_c),
      .wr_addr_i  (rd_waddr),
      .wr_data_i  (rd_wdata),
      .rdata_o    (rdata[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// Directed testbench for fwrisc_regfile_mp: default instance plus a
// 3-port / 16-entry / 16-bit variant.
module tb_fwrisc_regfile_mp;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [11:0] raddr;
  logic [63:0] rdata;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;

  logic        reset_s;
  logic        ready_s;
  logic [11:0] raddr_s;
  logic [47:0] rdata_s;
  logic [3:0]  waddr_s;
  logic [15:0] wdata_s;
  logic        wen_s;

  int checks;
  int failures;

  fwrisc_regfile_mp dut (
    .clock    (clk),
    .reset    (reset),
    .ready    (ready),
    .raddr    (raddr),
    .rdata    (rdata),
    .rd_waddr (rd_waddr),
    .rd_wdata (rd_wdata),
    .rd_wen   (rd_wen)
  );

  fwrisc_regfile_mp #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (4),
    .NUM_RD_PORTS (3)
  ) dut_s (
    .clock    (clk),
    .reset    (reset_s),
    .ready    (ready_s),
    .raddr    (raddr_s),
    .rdata    (rdata_s),
    .rd_waddr (waddr_s),
    .rd_wdata (wdata_s),
    .rd_wen   (wen_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises on the default instance (bounded)
  task automatic count_clear(output int n);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (ready) break;
    end
  endtask

  task automatic write_main(input logic [5:0] a, input logic [31:0] d);
    rd_wen = 1'b1; rd_waddr = a; rd_wdata = d;
    tick();
    rd_wen = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; raddr = {6'd5, 6'd9};
    tick(); tick();
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", ready);
    end
    checks++;
    if (rdata !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    reset = 1'b0;
    count_clear(n);
    checks++;
    if (n !== 64) begin
      failures++; $display("FAIL initial_clear_cycles got=%0d exp=64", n);
    end
  endtask

  task automatic test_basic_rw();
    write_main(6'd5, 32'hDEADBEEF);
    raddr = {6'd5, 6'd5};
    tick();
    checks++;
    if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      failures++; $display("FAIL basic_rw got=%h exp=%h", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    end
  endtask

  task automatic test_addr0();
    write_main(6'd0, 32'hFFFFFFFF);
    raddr = {6'd0, 6'd0};
    tick();
    checks++;
    if (rdata !== 64'h0) begin
      failures++; $display("FAIL addr0_read got=%h exp=0", rdata);
    end
    raddr = {6'd5, 6'd0};
    tick();
    checks++;
    if (rdata !== {32'hDEADBEEF, 32'h0}) begin
      failures++; $display("FAIL addr0_mixed got=%h exp=%h", rdata, {32'hDEADBEEF, 32'h0});
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp0;
`ifdef FWRISC_REGFILE_BYPASS_EN
    exp0 = 32'h22222222;
`else
    exp0 = 32'h11111111;
`endif
    write_main(6'd7, 32'h11111111);
    rd_wen = 1'b1; rd_waddr = 6'd7; rd_wdata = 32'h22222222;
    raddr = {6'd5, 6'd7};
    tick();
    rd_wen = 1'b0;
    checks++;
    if (rdata[31:0] !== exp0) begin
      failures++; $display("FAIL collision_same_cycle got=%h exp=%h", rdata[31:0], exp0);
    end
    checks++;
    if (rdata[63:32] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL collision_other_port got=%h exp=deadbeef", rdata[63:32]);
    end
    tick();
    checks++;
    if (rdata[31:0] !== 32'h22222222) begin
      failures++; $display("FAIL collision_next_read got=%h exp=22222222", rdata[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      rd_wen = 1'b1; rd_waddr = 6'(i + 10); rd_wdata = 32'h10000000 + 32'(i);
      tick();
    end
    rd_wen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      raddr = {6'(15 - i), 6'(i + 10)};
      tick();
      checks++;
      if (rdata !== {32'h10000000 + 32'(5 - i), 32'h10000000 + 32'(i)}) begin
        failures++;
        $display("FAIL back_to_back_%0d got=%h exp=%h", i, rdata,
                 {32'h10000000 + 32'(5 - i), 32'h10000000 + 32'(i)});
      end
    end
  endtask

  task automatic test_reset_clear();
    int n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ready !== 1'b0 || rdata !== 64'h0) begin
      failures++; $display("FAIL rerun_reset got ready=%b rdata=%h exp ready=0 rdata=0", ready, rdata);
    end
    reset = 1'b0;
    raddr = {6'd5, 6'd7};
    count_clear(n);
    checks++;
    if (n !== 64) begin
      failures++; $display("FAIL reclear_cycles got=%0d exp=64", n);
    end
    tick();
    checks++;
    if (rdata !== 64'h0) begin
      failures++; $display("FAIL cleared_read got=%h exp=0", rdata);
    end
    raddr = {6'd14, 6'd63};
    tick();
    checks++;
    if (rdata !== 64'h0) begin
      failures++; $display("FAIL cleared_read_hi got=%h exp=0", rdata);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    int early_ready;
    write_main(6'd3, 32'h33333333);
    reset = 1'b1; tick();
    reset = 1'b0;
    early_ready = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready) early_ready++;
    end
    reset = 1'b1; tick();
    checks++;
    if (early_ready !== 0 || ready !== 1'b0) begin
      failures++; $display("FAIL mid_clear_ready got early=%0d ready=%b exp 0", early_ready, ready);
    end
    reset = 1'b0;
    raddr = {6'd3, 6'd3};
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      rd_wen = 1'b0;
      if (ready) break;
      if (n == 10) begin
        checks++;
        if (rdata !== 64'h0) begin
          failures++; $display("FAIL sweep_rdata got=%h exp=0", rdata);
        end
      end
      if (n == 20) begin
        rd_wen = 1'b1; rd_waddr = 6'd3; rd_wdata = 32'hABCD1234;
      end
    end
    checks++;
    if (n !== 64) begin
      failures++; $display("FAIL mid_clear_restart_cycles got=%0d exp=64", n);
    end
    tick();
    checks++;
    if (rdata !== 64'h0) begin
      failures++; $display("FAIL dropped_write got=%h exp=0", rdata);
    end
  endtask

  task automatic test_param_variant();
    int n;
    reset_s = 1'b1; raddr_s = {4'd3, 4'd2, 4'd1};
    tick();
    checks++;
    if (ready_s !== 1'b0 || rdata_s !== 48'h0) begin
      failures++; $display("FAIL small_reset got ready=%b rdata=%h exp 0", ready_s, rdata_s);
    end
    reset_s = 1'b0;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (ready_s) break;
    end
    checks++;
    if (n !== 16) begin
      failures++; $display("FAIL small_clear_cycles got=%0d exp=16", n);
    end
    wen_s = 1'b1;
    waddr_s = 4'd1;  wdata_s = 16'hA001; tick();
    waddr_s = 4'd2;  wdata_s = 16'hB002; tick();
    waddr_s = 4'd3;  wdata_s = 16'hC003; tick();
    waddr_s = 4'd15; wdata_s = 16'hF00F; tick();
    wen_s = 1'b0;
    raddr_s = {4'd3, 4'd2, 4'd1};
    tick();
    checks++;
    if (rdata_s !== {16'hC003, 16'hB002, 16'hA001}) begin
      failures++; $display("FAIL small_three_ports got=%h exp=c003b002a001", rdata_s);
    end
    raddr_s = {4'd0, 4'd15, 4'd2};
    tick();
    checks++;
    if (rdata_s !== {16'h0000, 16'hF00F, 16'hB002}) begin
      failures++; $display("FAIL small_top_and_zero got=%h exp=0000f00fb002", rdata_s);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; raddr = '0; rd_waddr = '0; rd_wdata = '0; rd_wen = 1'b0;
    reset_s = 1'b1; raddr_s = '0; waddr_s = '0; wdata_s = '0; wen_s = 1'b0;
    tick();
    test_reset();
    test_basic_rw();
    test_addr0();
    test_collision();
    test_back_to_back();
    test_reset_clear();
    test_reset_mid_clear();
    test_param_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
